grayscale: RTL

Front-end stage of the edge-detection pipeline and the producer side of the gray-pixel FIFO interface. Pops 24-bit RGB pixels from the input FIFO and computes gray = floor((R+G+B)/3) in a two-stage stall-able pipeline. Pushes 8-bit results, in raster order, into the gray FIFO that the Sobel stage drains. Counts pixels per frame and pulses `done` after the last gray pixel of a frame is written.

---
 rtl/edge_pkg.sv | 18 +
 rtl/grayscale_if.sv | 40 ++++
 rtl/div3.sv | 14 +
 rtl/grayscale.sv | 119 +++++++++++
 4 files changed

// File: rtl/edge_pkg.sv
// Shared definitions for the edge-detection pipeline: image geometry defaults,
// divide-by-3 reciprocal constants and the grayscale stage state encoding.
package edge_pkg;

    localparam int IMG_WIDTH_DEF  = 540;
    localparam int IMG_HEIGHT_DEF = 720;

    // floor(x/3) == (x*683)>>11 holds exactly for every x in 0..765
    localparam int DIV3_MUL   = 683;
    localparam int DIV3_SHIFT = 11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } gray_state_t;

endpackage

// File: rtl/grayscale_if.sv
// FIFO-side signal bundle of the grayscale stage: RGB FIFO read port, gray FIFO
// write port, end-of-frame pulse and the FSM state for observation.
interface grayscale_if;
    import edge_pkg::*;

    // Handshakes: a pop happens in any cycle with in_rd_en=1 (only raised while
    // in_empty=0, data taken from show-ahead in_dout); a push happens in any
    // cycle with gray_wr_en=1 (only raised while gray_full=0, data on gray_din).
    logic        in_rd_en;
    logic        in_empty;
    logic [23:0] in_dout;
    logic        gray_wr_en;
    logic        gray_full;
    logic [7:0]  gray_din;
    logic        done;
    gray_state_t state;

    modport master (
        output in_rd_en,
        output gray_wr_en,
        output gray_din,
        output done,
        output state,
        input  in_empty,
        input  in_dout,
        input  gray_full
    );

    modport slave (
        input  in_rd_en,
        input  gray_wr_en,
        input  gray_din,
        input  done,
        input  state,
        output in_empty,
        output in_dout,
        output gray_full
    );

endinterface

// File: rtl/div3.sv
// Combinational exact divide-by-3 for sums of three 8-bit channels (0..765),
// done as a reciprocal multiply so no divider is inferred.
module div3
    import edge_pkg::*;
(
    input  logic [9:0] sum_i,
    output logic [7:0] gray_o
);

    localparam int PW = 20;

    assign gray_o = 8'((PW'(sum_i) * PW'(DIV3_MUL)) >> DIV3_SHIFT);

endmodule

// File: rtl/grayscale.sv
// RGB-to-gray front end: pops RGB pixels, averages the three channels through a
// two-stage stallable pipeline and pushes gray pixels, pulsing done per frame.
module grayscale
    import edge_pkg::*;
#(
    parameter int IMG_WIDTH  = IMG_WIDTH_DEF,
    parameter int IMG_HEIGHT = IMG_HEIGHT_DEF
) (
    input logic         clock,
    input logic         reset,
    grayscale_if.master g
);

    localparam int TOTAL = IMG_WIDTH * IMG_HEIGHT;
    localparam int CW    = $clog2(TOTAL + 1);
    localparam logic [CW-1:0] TOTAL_C = CW'(TOTAL);
    localparam logic [CW-1:0] LAST_C  = CW'(TOTAL - 1);

    gray_state_t   state_q, state_d;
    logic [CW-1:0] rd_count_q, rd_count_d;
    logic [CW-1:0] wr_count_q, wr_count_d;
    logic          s1_valid_q, s1_valid_d;
    logic [9:0]    s1_sum_q, s1_sum_d;
    logic          s2_valid_q, s2_valid_d;
    logic [7:0]    s2_gray_q, s2_gray_d;

    logic          advance;
    logic          pop;
    logic          push;
    logic          done;
    logic [7:0]    div_gray;

    // A valid S2 that cannot drain freezes the whole pipeline
    assign advance = !(s2_valid_q && g.gray_full);
    assign push    = s2_valid_q && !g.gray_full;

    div3 u_div3 (
        .sum_i  (s1_sum_q),
        .gray_o (div_gray)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (!g.in_empty) state_d = RUN;
            RUN:  if (push && (wr_count_q == LAST_C)) state_d = DONE;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        pop  = advance && !g.in_empty && (state_q == RUN) && (rd_count_q < TOTAL_C);
        done = (state_q == DONE);
    end

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_sum_d   = s1_sum_q;
        s2_valid_d = s2_valid_q;
        s2_gray_d  = s2_gray_q;
        if (advance) begin
            s1_valid_d = pop;
            if (pop) begin
                s1_sum_d = 10'(g.in_dout[23:16]) + 10'(g.in_dout[15:8]) + 10'(g.in_dout[7:0]);
            end
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_gray_d = div_gray;
            end
        end
    end

    // Counters restart in DONE so the next frame begins at pixel 0
    always_comb begin
        rd_count_d = rd_count_q;
        wr_count_d = wr_count_q;
        if (state_q == DONE) begin
            rd_count_d = '0;
            wr_count_d = '0;
        end else begin
            if (pop)  rd_count_d = rd_count_q + 1'b1;
            if (push) wr_count_d = wr_count_q + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            s1_valid_q <= 1'b0;
            s1_sum_q   <= '0;
            s2_valid_q <= 1'b0;
            s2_gray_q  <= '0;
            rd_count_q <= '0;
            wr_count_q <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_sum_q   <= s1_sum_d;
            s2_valid_q <= s2_valid_d;
            s2_gray_q  <= s2_gray_d;
            rd_count_q <= rd_count_d;
            wr_count_q <= wr_count_d;
        end
    end

    assign g.in_rd_en   = pop;
    assign g.gray_wr_en = push;
    assign g.gray_din   = s2_gray_q;
    assign g.done       = done;
    assign g.state      = state_q;

endmodule
